// File: rtl/uart_rx_os16_if.sv
// Byte stream from the UART receiver to its consumer: data qualified by valid, with ready backpressure.
interface uart_rx_os16_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: synchronises rx, validates start, majority-votes each bit,
// checks the stop bit and hands bytes to a ready/valid consumer with overrun/framing flags.
module uart_rx_os16 #(
    parameter int DATA_BITS = 8
) (
    input  logic           clk_50m,
    input  logic           rst,
    input  logic           rxclk_en,
    input  logic           rx,
    uart_rx_os16_if.master rx_byte,
    output logic           frame_err,
    output logic           overrun
);

    localparam int               IDX_W       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);
    localparam int               SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state_reg;
    logic [3:0]             cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_next;
    logic                   samp7_reg;
    logic                   samp8_reg;
    logic                   vote_reg;
    logic [DATA_BITS-1:0]   data_reg;
    logic                   valid_reg;
    logic                   frame_err_reg;
    logic                   overrun_reg;
    logic [SYNC_STAGES-1:0] sync_reg;

    logic rx_s;
    logic vote_now;
    logic in_frame;
    logic stop_tick;
    logic load;
    logic accept;

    // Two-flop synchroniser; resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // Samples at cnt 7 and 8 are held; the cnt 9 sample is the live line, so the vote resolves on that tick.
    assign vote_now  = (samp7_reg & samp8_reg) | (samp7_reg & rx_s) | (samp8_reg & rx_s);
    assign in_frame  = (state_reg == ST_START) || (state_reg == ST_DATA) || (state_reg == ST_STOP);
    assign stop_tick = rxclk_en && (state_reg == ST_STOP) && (cnt_reg == 4'd9);
    assign load      = stop_tick && vote_now;
    assign accept    = valid_reg && rx_byte.ready;

    // LSB arrives first, so each new bit enters at the MSB and the word slides right.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS - 1; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi+1];
        end
    endgenerate
    assign shift_next[DATA_BITS-1] = vote_reg;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            samp7_reg     <= 1'b0;
            samp8_reg     <= 1'b0;
            vote_reg      <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;

            // Output stage runs every clock; a load coincident with an accept refills without a gap.
            if (load) begin
                if (!valid_reg || accept) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (accept) begin
                valid_reg <= 1'b0;
            end

            if (rxclk_en) begin
                if (in_frame) begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd7) begin
                        samp7_reg <= rx_s;
                    end
                    if (cnt_reg == 4'd8) begin
                        samp8_reg <= rx_s;
                    end
                end

                unique case (state_reg)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_reg <= ST_START;
                            cnt_reg   <= 4'd0;
                        end
                    end

                    ST_START: begin
                        if (cnt_reg == 4'd9 && vote_now) begin
                            state_reg <= ST_IDLE;
                        end else if (cnt_reg == 4'd15) begin
                            state_reg <= ST_DATA;
                            idx_reg   <= '0;
                        end
                    end

                    ST_DATA: begin
                        if (cnt_reg == 4'd9) begin
                            vote_reg <= vote_now;
                        end
                        if (cnt_reg == 4'd15) begin
                            shift_reg <= shift_next;
                            if (idx_reg == LAST_IDX) begin
                                state_reg <= ST_STOP;
                            end else begin
                                idx_reg <= idx_reg + 1'b1;
                            end
                        end
                    end

                    // Decide at mid stop bit so the next start edge can be caught early.
                    ST_STOP: begin
                        if (cnt_reg == 4'd9) begin
                            if (vote_now) begin
                                state_reg <= ST_IDLE;
                            end else begin
                                frame_err_reg <= 1'b1;
                                shift_reg     <= '0;
                                state_reg     <= ST_BREAK;
                            end
                        end
                    end

                    // A held-low line stays here, so a break reports a single framing error.
                    ST_BREAK: begin
                        if (rx_s) begin
                            state_reg <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_byte.data  = data_reg;
    assign rx_byte.valid = valid_reg;
    assign frame_err     = frame_err_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: table of whole frames plus hand-written glitch,
// backpressure, coincident accept/load and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_os16;

    logic clk_50m = 1'b0;
    logic rst;
    logic rxclk_en;
    logic rx;
    logic frame_err;
    logic overrun;

    uart_rx_os16_if #(.DATA_BITS(8)) rx_byte ();

    uart_rx_os16 #(.DATA_BITS(8)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .rxclk_en  (rxclk_en),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #10 clk_50m = ~clk_50m;

    int n_checks = 0;
    int n_errors = 0;

    // Tick strobe: one clock high every tick_period clocks; tick_num names the most recent tick.
    int tick_period = 35;
    int tick_div    = 0;
    int tick_num    = 0;

    initial begin
        rxclk_en = 1'b0;
        forever begin
            @(posedge clk_50m);
            #1;
            if (tick_div >= tick_period - 1) begin
                tick_div = 0;
                rxclk_en = 1'b1;
                tick_num++;
            end else begin
                tick_div++;
                rxclk_en = 1'b0;
            end
        end
    end

    // Monitor: cumulative counters only; the main sequence compares deltas against snapshots.
    int         valid_clks = 0;
    int         fe_cnt     = 0;
    int         ov_cnt     = 0;
    int         stab_err   = 0;
    int         rise_tick  = -1;
    logic [7:0] acc_q[$];

    initial begin
        logic       prev_valid;
        logic       prev_acc;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_acc   = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk_50m);
            if (rx_byte.valid === 1'b1) valid_clks++;
            if (rx_byte.valid === 1'b1 && !prev_valid) rise_tick = tick_num;
            if (prev_valid && rx_byte.valid === 1'b1 && !prev_acc && rx_byte.data !== prev_data) stab_err++;
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
            prev_acc = (rx_byte.valid === 1'b1) && (rx_byte.ready === 1'b1);
            if (prev_acc) acc_q.push_back(rx_byte.data);
            prev_valid = (rx_byte.valid === 1'b1);
            prev_data  = rx_byte.data;
        end
    end

    int base_v, base_fe, base_ov, base_acc;
    int last_edge;

    task automatic snap();
        base_v   = valid_clks;
        base_fe  = fe_cnt;
        base_ov  = ov_cnt;
        base_acc = acc_q.size();
    endtask

    function automatic int acc_at(input int k);
        if (base_acc + k < acc_q.size()) return int'(acc_q[base_acc + k]);
        return 'h1FF;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk_50m); while (rxclk_en !== 1'b1);
        #1;
    endtask

    // Sends one frame; optionally raises ready for exactly the clock of the stop decision.
    task automatic send_byte(input logic [7:0] val, input int tpb, input logic stop,
                             input int brk, input logic pulse_ready);
        wait_tick();
        rx        = 1'b0;
        last_edge = tick_num;
        repeat (tpb) wait_tick();
        for (int i = 0; i < 8; i++) begin
            rx = val[i];
            repeat (tpb) wait_tick();
        end
        rx = stop;
        for (int k = 0; k < tpb; k++) begin
            if (pulse_ready && tick_num == last_edge + 154) begin
                repeat (tick_period - 1) @(posedge clk_50m);
                #1;
                rx_byte.ready = 1'b1;
                wait_tick();
                rx_byte.ready = 1'b0;
            end else begin
                wait_tick();
            end
        end
        repeat (brk) wait_tick();
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] val;
        int         tpb;
        logic       stop;
        int         brk;
        int         div;
        int         exp_n;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] part;
        vecs[0] = '{8'hA5, 16, 1'b1, 0,  35, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 16, 1'b1, 0,  8,  1, 8'h00, 0};
        vecs[2] = '{8'hFF, 16, 1'b1, 0,  8,  1, 8'hFF, 0};
        vecs[3] = '{8'h55, 16, 1'b0, 60, 8,  0, 8'h00, 1};
        vecs[4] = '{8'h81, 16, 1'b1, 0,  8,  1, 8'h81, 0};
        vecs[5] = '{8'hF0, 15, 1'b1, 0,  8,  1, 8'hF0, 0};
        vecs[6] = '{8'h0F, 17, 1'b1, 0,  8,  1, 8'h0F, 0};

        rst           = 1'b1;
        rx            = 1'b1;
        rx_byte.ready = 1'b1;
        repeat (3) @(posedge clk_50m);
        #1;
        check("reset_data", int'(rx_byte.data), 0);
        check("reset_valid", int'(rx_byte.valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        rst         = 1'b0;
        tick_period = 8;
        repeat (4) wait_tick();

        // Start glitch shorter than the vote window, then a real frame.
        snap();
        wait_tick();
        rx = 1'b0;
        repeat (4) wait_tick();
        rx = 1'b1;
        repeat (30) wait_tick();
        check("glitch_valid", valid_clks - base_v, 0);
        check("glitch_frame_err", fe_cnt - base_fe, 0);
        $display("tx glitch: valid_clks=%0d frame_err=%0d", valid_clks - base_v, fe_cnt - base_fe);
        snap();
        send_byte(8'h3C, 16, 1'b1, 0, 1'b0);
        repeat (20) wait_tick();
        check("after_glitch_count", acc_q.size() - base_acc, 1);
        check("after_glitch_data", acc_at(0), 'h3C);
        $display("tx after_glitch: got 0x%0h", acc_at(0));

        // Backpressure: second byte arrives back-to-back while the first is still pending.
        snap();
        rx_byte.ready = 1'b0;
        send_byte(8'h11, 16, 1'b1, 0, 1'b0);
        send_byte(8'h22, 16, 1'b1, 0, 1'b0);
        repeat (20) wait_tick();
        check("bp_valid", int'(rx_byte.valid), 1);
        check("bp_data", int'(rx_byte.data), 'h11);
        check("bp_overrun", ov_cnt - base_ov, 1);
        check("bp_no_accept", acc_q.size() - base_acc, 0);
        @(posedge clk_50m);
        #1;
        rx_byte.ready = 1'b1;
        @(posedge clk_50m);
        #1;
        rx_byte.ready = 1'b0;
        check("bp_drain_valid", int'(rx_byte.valid), 0);
        check("bp_drain_data", acc_at(0), 'h11);
        $display("tx backpressure: held=0x11 overruns=%0d drained=0x%0h", ov_cnt - base_ov, acc_at(0));

        // Accept on exactly the load clock of the next byte.
        snap();
        send_byte(8'h11, 16, 1'b1, 0, 1'b0);
        send_byte(8'h22, 16, 1'b1, 0, 1'b1);
        repeat (10) wait_tick();
        check("coinc_data", int'(rx_byte.data), 'h22);
        check("coinc_valid", int'(rx_byte.valid), 1);
        check("coinc_overrun", ov_cnt - base_ov, 0);
        check("coinc_accepted", acc_at(0), 'h11);
        rx_byte.ready = 1'b1;
        repeat (4) wait_tick();
        check("coinc_drain", acc_at(1), 'h22);
        $display("tx coincident: accepted 0x%0h then 0x%0h", acc_at(0), acc_at(1));

        // Reset three data bits into a frame while a byte is pending.
        rx_byte.ready = 1'b0;
        send_byte(8'h5A, 16, 1'b1, 0, 1'b0);
        repeat (4) wait_tick();
        check("pre_reset_valid", int'(rx_byte.valid), 1);
        part = 8'hC6;
        wait_tick();
        rx = 1'b0;
        repeat (16) wait_tick();
        for (int i = 0; i < 3; i++) begin
            rx = part[i];
            repeat (16) wait_tick();
        end
        rst = 1'b1;
        @(posedge clk_50m);
        #1;
        check("midrst_data", int'(rx_byte.data), 0);
        check("midrst_valid", int'(rx_byte.valid), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_overrun", int'(overrun), 0);
        rst = 1'b0;
        rx  = 1'b1;
        snap();
        rx_byte.ready = 1'b1;
        repeat (30) wait_tick();
        check("midrst_quiet", (valid_clks - base_v) + (fe_cnt - base_fe), 0);
        $display("tx mid_frame_reset: outputs cleared");

        for (int i = 0; i < 7; i++) begin
            tick_period = vecs[i].div;
            repeat (2) wait_tick();
            snap();
            rise_tick     = -1;
            rx_byte.ready = 1'b1;
            send_byte(vecs[i].val, vecs[i].tpb, vecs[i].stop, vecs[i].brk, 1'b0);
            repeat (20) wait_tick();
            check($sformatf("v%0d_count", i), acc_q.size() - base_acc, vecs[i].exp_n);
            check($sformatf("v%0d_valid_clks", i), valid_clks - base_v, vecs[i].exp_n);
            check($sformatf("v%0d_frame_err", i), fe_cnt - base_fe, vecs[i].exp_fe);
            check($sformatf("v%0d_overrun", i), ov_cnt - base_ov, 0);
            if (vecs[i].exp_n != 0) begin
                check($sformatf("v%0d_data", i), acc_at(0), int'(vecs[i].exp_data));
                check($sformatf("v%0d_latency", i), rise_tick, last_edge + 155);
            end
            $display("tx v%0d: sent 0x%0h tpb=%0d stop=%0d got=0x%0h count=%0d frame_err=%0d",
                     i, vecs[i].val, vecs[i].tpb, vecs[i].stop, acc_at(0),
                     acc_q.size() - base_acc, fe_cnt - base_fe);
        end

        check("data_stable_while_valid", stab_err, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "time limit");
    end

endmodule
